// File: rtl/stream_pkg.sv
// Shared stream definitions for the 8-bit ready/valid pipeline stages.
package stream_pkg;

    localparam int unsigned STREAM_DATA_W = 8;

    typedef logic [STREAM_DATA_W-1:0] stream_data_t;

    // Pointer/count width for a power-of-two depth: address bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read.
// Contents are not cleared by reset; validity is tracked by the owner's pointers.
module stream_fifo_mem
    import stream_pkg::*;
#(
    parameter int unsigned DATA_W = STREAM_DATA_W,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned AW    = ptr_width(DEPTH) - 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: only an accepted push updates storage.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Elastic ready/valid buffer with occupancy count.
// Optional zero-latency path when empty: define STREAM_FIFO_BYPASS_EN.
module stream_fifo
    import stream_pkg::*;
#(
    parameter int unsigned DATA_W = STREAM_DATA_W,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned CNT_W = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_a_data,
    input  logic              in_a_valid,
    output logic              in_a_ready,
    output logic [DATA_W-1:0] out_a_data,
    output logic              out_a_valid,
    input  logic              out_a_ready,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned AW = CNT_W - 1;

    logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty, full;
    logic              push, pop;
    logic [DATA_W-1:0] rdata;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Depends only on registered state and rst, never on out_a_ready.
    assign in_a_ready = !full && !rst;
    assign count      = rst ? '0 : count_q;

`ifdef STREAM_FIFO_BYPASS_EN
    logic bypass;

    // Output mux: storage head when non-empty, otherwise the live input beat.
    always_comb begin
        bypass      = empty && in_a_valid && !rst;
        out_a_valid = !rst && (!empty || in_a_valid);
        out_a_data  = '0;
        if (!rst && !empty) begin
            out_a_data = rdata;
        end else if (bypass) begin
            out_a_data = in_a_data;
        end
        // A bypassed beat taken downstream this cycle never touches storage.
        push = in_a_valid && in_a_ready && !(bypass && out_a_ready);
        pop  = !rst && !empty && out_a_ready;
    end
`else
    // Output comes from storage only; zero it while nothing is valid.
    always_comb begin
        out_a_valid = !empty && !rst;
        out_a_data  = out_a_valid ? rdata : '0;
        push        = in_a_valid && in_a_ready;
        pop         = out_a_valid && out_a_ready;
    end
`endif

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    stream_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (in_a_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo: accepted input beats are queued, the monitor
// pops and compares on each output handshake and checks stall stability.
module tb_stream_fifo;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 3;
`ifdef STREAM_FIFO_BYPASS_EN
    localparam int STREAM_CNT = 0;
`else
    localparam int STREAM_CNT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_a_data;
    logic              in_a_valid;
    logic              in_a_ready;
    logic [DATA_W-1:0] out_a_data;
    logic              out_a_valid;
    logic              out_a_ready;
    logic [CNT_W-1:0]  count;

    int                n_cmp = 0;
    int                n_err = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic              stall_prev = 1'b0;
    logic [DATA_W-1:0] stall_data = '0;

    always #5 clk = ~clk;

    stream_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_a_data   (in_a_data),
        .in_a_valid  (in_a_valid),
        .in_a_ready  (in_a_ready),
        .out_a_data  (out_a_data),
        .out_a_valid (out_a_valid),
        .out_a_ready (out_a_ready),
        .count       (count)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at every falling edge: queue accepted beats, check emitted beats.
    task automatic monitor_step();
        if (in_a_valid && in_a_ready) begin
            exp_q.push_back(in_a_data);
        end
        if (out_a_valid && out_a_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {24'd0, out_a_data}, 32'hFFFF_FFFF);
            end else begin
                chk("out_data", {24'd0, out_a_data}, {24'd0, exp_q.pop_front()});
            end
        end
        if (stall_prev && !rst) begin
            chk("stall_valid", {31'd0, out_a_valid}, 32'd1);
            chk("stall_data", {24'd0, out_a_data}, {24'd0, stall_data});
        end
        stall_prev = out_a_valid && !out_a_ready && !rst;
        stall_data = out_a_data;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        bit ok = 1'b0;
        in_a_valid = 1'b1;
        in_a_data  = d;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_a_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        tick();
        in_a_valid = 1'b0;
        in_a_data  = 'x;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        out_a_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (count == '0 && !out_a_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("drain_done", {31'd0, ok}, 32'd1);
        chk("drain_scoreboard_empty", exp_q.size(), 32'd0);
        tick();
    endtask

    task automatic run_tests();
        int acc;
        int cyc;
        // Reset held for 3 cycles with a beat offered.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_in_ready", {31'd0, in_a_ready}, 32'd0);
            chk("rst_out_valid", {31'd0, out_a_valid}, 32'd0);
            chk("rst_out_data", {24'd0, out_a_data}, 32'd0);
            chk("rst_count", {29'd0, count}, 32'd0);
        end
        tick();
        rst        = 1'b0;
        in_a_valid = 1'b0;
        in_a_data  = 'x;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_a_ready}, 32'd1);
        chk("post_rst_count", {29'd0, count}, 32'd0);
        chk("post_rst_out_valid", {31'd0, out_a_valid}, 32'd0);
        tick();

        // Fill to full, hold an extra beat, then drain while it enters.
        out_a_ready = 1'b0;
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        in_a_valid = 1'b1;
        in_a_data  = 8'h55;
        @(negedge clk);
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_in_ready", {31'd0, in_a_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("full_hold_count", {29'd0, count}, 32'd4);
        tick();
        out_a_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_in_ready", {31'd0, in_a_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("after_pop_count", {29'd0, count}, 32'd3);
        chk("after_pop_in_ready", {31'd0, in_a_ready}, 32'd1);
        tick();
        in_a_valid = 1'b0;
        in_a_data  = 'x;
        @(negedge clk);
        chk("push_pop_count", {29'd0, count}, 32'd3);
        tick();
        drain();

        // Full with simultaneous pop: push refused, taken the next cycle.
        out_a_ready = 1'b0;
        send(8'hA1);
        send(8'hA2);
        send(8'hA3);
        send(8'hA4);
        in_a_valid  = 1'b1;
        in_a_data   = 8'hA5;
        out_a_ready = 1'b1;
        @(negedge clk);
        chk("fsp_count", {29'd0, count}, 32'd4);
        chk("fsp_in_ready", {31'd0, in_a_ready}, 32'd0);
        tick();
        out_a_ready = 1'b0;
        @(negedge clk);
        chk("fsp_count_next", {29'd0, count}, 32'd3);
        chk("fsp_in_ready_next", {31'd0, in_a_ready}, 32'd1);
        tick();
        in_a_valid = 1'b0;
        in_a_data  = 'x;
        @(negedge clk);
        chk("fsp_count_refill", {29'd0, count}, 32'd4);
        tick();
        drain();

        // Streaming at one beat per cycle.
        out_a_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_a_valid = 1'b1;
            in_a_data  = 8'h80 + 8'(i);
            @(negedge clk);
            if (i >= 1) begin
                chk("stream_count", {29'd0, count}, STREAM_CNT);
                chk("stream_out_valid", {31'd0, out_a_valid}, 32'd1);
            end
            tick();
        end
        in_a_valid = 1'b0;
        in_a_data  = 'x;
        drain();

        // Random valid/ready at 50% for 1000 accepted beats.
        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            in_a_valid  = 1'($urandom % 2);
            in_a_data   = in_a_valid ? 8'($urandom) : 'x;
            out_a_ready = 1'($urandom % 2);
            @(negedge clk);
            if (in_a_valid && in_a_ready) acc++;
            tick();
            cyc++;
        end
        chk("random_beats_accepted", acc, 32'd1000);
        in_a_valid = 1'b0;
        in_a_data  = 'x;
        drain();

        // Reset mid-burst discards stored beats.
        out_a_ready = 1'b0;
        send(8'hC1);
        send(8'hC2);
        send(8'hC3);
        @(negedge clk);
        chk("mid_count_before", {29'd0, count}, 32'd3);
        tick();
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_count", {29'd0, count}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_a_valid}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_after_count", {29'd0, count}, 32'd0);
        chk("mid_after_out_valid", {31'd0, out_a_valid}, 32'd0);
        tick();
        out_a_ready = 1'b1;
        send(8'h5A);
        drain();
    endtask

    initial begin
        rst         = 1'b1;
        in_a_valid  = 1'b1;
        in_a_data   = 8'hAA;
        out_a_ready = 1'b0;
        fork
            begin
                forever begin
                    @(negedge clk);
                    monitor_step();
                end
            end
            begin
                run_tests();
            end
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Elastic buffer that sits directly downstream of the 8-bit ready/valid `top` stage.
- Consumes that stage's out_a stream and re-presents it, in order, to the next consumer.
- Decouples backpressure between stages and absorbs bursts of up to DEPTH beats.
- Reports occupancy for debug and flow monitoring.

Parameters:
- DATA_W, 8: payload width in bits.
- DEPTH, 4: number of entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1: width of the count output; derived, not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_a_data  input  DATA_W  upstream payload.
- in_a_valid  input  1  upstream beat present.
- in_a_ready  output  1  FIFO can accept a beat.
- out_a_data  output  DATA_W  head-of-queue payload.
- out_a_valid  output  1  head-of-queue valid.
- out_a_ready  input  1  downstream accepts the beat.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Clocking: single clock domain. Reset is synchronous, active-high (fixed).
- Transfer rules:
  - Push occurs when in_a_valid & in_a_ready.
  - Pop occurs when out_a_valid & out_a_ready.
- Reset values, while rst is high and on the first cycle after:
  - in_a_ready = 0 while rst is asserted; 1 on the first cycle after deassertion.
  - out_a_valid = 0.
  - out_a_data = 0.
  - count = 0.
  - Read and write pointers = 0.
- Reset mid-operation: all stored beats are discarded and nothing is popped in the reset cycle.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits and wrap naturally.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and the low bits are equal.
- in_a_ready:
  - Equals !full && !rst.
  - Has no combinational path from out_a_ready.
  - When full, a simultaneous pop does not admit a push in the same cycle; that push is accepted the following cycle.
- out_a_valid = !empty. out_a_data = mem[rd_ptr low bits], a combinational read of registered storage.
- Latency: a beat pushed into an empty FIFO appears on out_a_valid/out_a_data in the cycle after acceptance (1 cycle).
- count:
  - Push only: count + 1.
  - Pop only: count - 1.
  - Push and pop together: unchanged.
  - Never exceeds DEPTH and never goes below 0.
- Stability: while out_a_valid=1 and out_a_ready=0, out_a_data and out_a_valid hold stable.
- Ordering: strict FIFO; no beat is dropped or duplicated.
- in_a_valid while in_a_ready=0 has no effect on state.
- Unknowns: X on in_a_data with in_a_valid=0 must not propagate into stored state.

Optional Feature:
Macro: STREAM_FIFO_BYPASS_EN
- Defined (bypass on): when the FIFO is empty and in_a_valid=1, the beat is presented combinationally that same cycle.
  - out_a_valid = in_a_valid; out_a_data = in_a_data.
  - If out_a_ready=1 the beat completes with zero latency; storage is not written and count stays 0.
  - If out_a_ready=0 the beat is written normally.
  - in_a_ready is unchanged (!full).
- Undefined: out_a_valid/out_a_data come only from storage, giving 1-cycle minimum latency. This is the default build.

Decomposition:
- Package stream_pkg holds:
  - STREAM_DATA_W = 8 constant.
  - typedef stream_data_t = logic [STREAM_DATA_W-1:0].
  - Helper function for the pointer/count width from depth.
  - Shared with the neighbouring stages.
- One sub-module, stream_fifo_mem:
  - DEPTH x DATA_W register array.
  - Synchronous write port (we, waddr, wdata); asynchronous read port (raddr, rdata).
  - Reset does not clear the array.
- The stream_fifo top holds pointers, flags, count and the bypass mux.

Test Plan:
- Reset: hold rst=1 for 3 cycles with in_a_valid=1 -> in_a_ready=0, out_a_valid=0, count=0; after release, in_a_ready=1.
- Fill/drain: out_a_ready=0, push 0x11,0x22,0x33,0x44 -> count=4, in_a_ready=0 after the 4th; 0x55 held with in_a_valid=1 is not accepted. Set out_a_ready=1 -> outputs 0x11..0x44 then 0x55 in order, count returns to 0.
- Full with simultaneous pop: count=4, in_a_valid=1, out_a_ready=1 -> pop occurs, push refused that cycle; count=3, then 4 the next cycle.
- Streaming: in_a_valid=1 and out_a_ready=1 for 20 cycles with an incrementing payload -> count stays at 1 after the first cycle, throughput 1 beat/cycle, ordering preserved. With STREAM_FIFO_BYPASS_EN, count stays 0 and latency is 0.
- Pointer wrap and stall: random valid/ready at 50% for 1000 beats -> scoreboard match, no loss or duplication, out_a_data stable whenever the output is stalled.
- Reset mid-burst: with count=3, assert rst for 1 cycle -> count=0 and out_a_valid=0 the next cycle; old data is never emitted afterwards.
